// File: rtl/l2cache_req_arbiter.sv
// Arbitrates icache reads, dcache reads/writes and cache ops into one sticky offer to the L2 FSM.
// Selection takes 1 cycle, and acceptance is forwarded combinationally; the arbiter idles 1 cycle between offers.
module l2cache_req_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_req,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              dcache_req,
    input  logic              dcache_wr,
    input  logic              dcache_suc,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [DATA_W-1:0] dcache_wdata,
    input  logic              op_req,
    input  logic [31:0]       op_code,
    input  logic [31:0]       op_addr,
    output logic              icache_addrOK,
    output logic              dcache_addrOK,
    output logic              op_ack,
    output logic [1:0]        arb_from,
    output logic [ADDR_W-1:0] arb_addr,
    output logic [DATA_W-1:0] arb_wdata,
    output logic              arb_suc,
    output logic              arb_opflag,
    output logic [31:0]       arb_opcode,
    output logic [31:0]       arb_opaddr,
    input  logic              fsm_icache_addrOK,
    input  logic              fsm_dcache_addrOK,
    input  logic              fsm_idle
);

    typedef enum logic [1:0] {IDLE, OFFER_I, OFFER_D, OFFER_OP} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        from_q, from_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              suc_q, suc_d;
    logic [31:0]       opcode_q, opcode_d;
    logic [31:0]       opaddr_q, opaddr_d;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        from_d       = from_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        suc_d        = suc_q;
        opcode_d     = opcode_q;
        opaddr_d     = opaddr_q;
        case (state_q)
            IDLE: begin
                if (op_req) begin
                    state_d  = OFFER_OP;
                    from_d   = 2'b00;
                    opcode_d = op_code;
                    opaddr_d = op_addr;
                // On a tie the icache wins only if the dcache was granted last.
                end else if (icache_req && (!dcache_req || last_grant_q)) begin
                    state_d = OFFER_I;
                    from_d  = 2'b01;
                    addr_d  = icache_addr;
                    wdata_d = '0;
                    suc_d   = 1'b0;
                end else if (dcache_req) begin
                    state_d = OFFER_D;
                    from_d  = {1'b1, dcache_wr};
                    addr_d  = dcache_addr;
                    wdata_d = dcache_wdata;
                    suc_d   = dcache_suc;
                end
            end
            OFFER_I: begin
                if (fsm_icache_addrOK) begin
                    state_d      = IDLE;
                    from_d       = 2'b00;
                    last_grant_d = 1'b0;
                end
            end
            OFFER_D: begin
                // Strongly-ordered accesses wait here indefinitely as well.
                if (fsm_dcache_addrOK) begin
                    state_d      = IDLE;
                    from_d       = 2'b00;
                    last_grant_d = 1'b1;
                end
            end
            OFFER_OP: begin
                if (fsm_idle) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            from_q       <= 2'b00;
            addr_q       <= '0;
            wdata_q      <= '0;
            suc_q        <= 1'b0;
            opcode_q     <= '0;
            opaddr_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            from_q       <= from_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            suc_q        <= suc_d;
            opcode_q     <= opcode_d;
            opaddr_q     <= opaddr_d;
        end
    end

    // Pulses are masked during reset so an abandoned offer is never acknowledged.
    assign icache_addrOK = !rst && (state_q == OFFER_I)  && fsm_icache_addrOK;
    assign dcache_addrOK = !rst && (state_q == OFFER_D)  && fsm_dcache_addrOK;
    assign op_ack        = !rst && (state_q == OFFER_OP) && fsm_idle;
    assign arb_opflag    = op_ack;
    assign arb_from      = from_q;
    assign arb_addr      = addr_q;
    assign arb_wdata     = wdata_q;
    assign arb_suc       = suc_q;
    assign arb_opcode    = opcode_q;
    assign arb_opaddr    = opaddr_q;

endmodule
